// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard controller with a DEPTH-entry shifting destination scoreboard.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined; otherwise they read 0.

module fwd_src_sel #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = 2
) (
    input  logic [DEPTH-1:0]              sb_vld,
    input  logic [DEPTH-1:0]              sb_we,
    input  logic [DEPTH-1:0]              sb_load,
    input  logic [DEPTH-1:0][RADDR_W-1:0] sb_rd,
    input  logic [RADDR_W-1:0]            src,
    input  logic                          used,
    input  logic [XLEN-1:0]               rf_data,
    input  logic [DEPTH*XLEN-1:0]         stage_data,
    output logic [XLEN-1:0]               op,
    output logic [SEL_W-1:0]              sel,
    output logic                          not_ready
);
    // Walk oldest to youngest so the youngest match overrides.
    always_comb begin
        op        = rf_data;
        sel       = '0;
        not_ready = 1'b0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (sb_vld[k] && sb_we[k] && (sb_rd[k] == src) && (src != '0) && used) begin
                if (sb_load[k] && (k < LOAD_LAT)) begin
                    op        = rf_data;
                    sel       = '0;
                    not_ready = 1'b1;
                end else begin
                    op        = stage_data[k*XLEN +: XLEN];
                    sel       = SEL_W'(k+1);
                    not_ready = 1'b0;
                end
            end
        end
    end
endmodule

module fwd_hazard_unit #(
    parameter int XLEN      = 32,
    parameter int RADDR_W   = 5,
    parameter int DEPTH     = 3,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 2,
    localparam int SEL_W    = $clog2(DEPTH+1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [RADDR_W-1:0]      id_rs1,
    input  logic [RADDR_W-1:0]      id_rs2,
    input  logic                    id_rs1_used,
    input  logic                    id_rs2_used,
    input  logic [RADDR_W-1:0]      id_rd,
    input  logic                    id_rd_we,
    input  logic                    id_is_load,
    input  logic                    ex_redirect,
    input  logic [XLEN-1:0]         rf_rs1_data,
    input  logic [XLEN-1:0]         rf_rs2_data,
    input  logic [DEPTH*XLEN-1:0]   stage_data,
    output logic [XLEN-1:0]         op_a,
    output logic [XLEN-1:0]         op_b,
    output logic [SEL_W-1:0]        sel_a,
    output logic [SEL_W-1:0]        sel_b,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    bubble_ex,
    output logic                    flush_id,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             flush_cnt
);
    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              cnt, cnt_nxt;
    logic [DEPTH-1:0]              sb_vld, sb_we, sb_load;
    logic [DEPTH-1:0][RADDR_W-1:0] sb_rd;
    logic [1:0][RADDR_W-1:0]       src;
    logic [1:0]                    used, nr;
    logic [1:0][XLEN-1:0]          rf, op;
    logic [1:0][SEL_W-1:0]         sel;
    logic                          redir, flushing, stall, issue;

    assign src  = {id_rs2, id_rs1};
    assign used = {id_rs2_used, id_rs1_used};
    assign rf   = {rf_rs2_data, rf_rs1_data};

    for (genvar i = 0; i < 2; i++) begin : g_src
        fwd_src_sel #(
            .XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
        ) u_sel (
            .sb_vld(sb_vld), .sb_we(sb_we), .sb_load(sb_load), .sb_rd(sb_rd),
            .src(src[i]), .used(used[i]), .rf_data(rf[i]), .stage_data(stage_data),
            .op(op[i]), .sel(sel[i]), .not_ready(nr[i])
        );
    end

    assign op_a = op[0];
    assign op_b = op[1];
    assign sel_a = sel[0];
    assign sel_b = sel[1];

    // Redirect is masked by reset so every control output is 0 while rst_n is low.
    assign redir     = ex_redirect & rst_n;
    assign flushing  = redir | (state == FLUSH);
    assign stall     = id_valid & ~flushing & (|nr);
    assign issue     = id_valid & ~stall & ~flushing;
    assign stall_if  = stall;
    assign stall_id  = stall;
    assign bubble_ex = stall | flushing;
    assign flush_id  = flushing;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: if (redir && (FLUSH_CYC > 1)) begin
                state_nxt = FLUSH;
                cnt_nxt   = CNT_W'(FLUSH_CYC-1);
            end
            FLUSH: if (redir) begin
                cnt_nxt = CNT_W'(FLUSH_CYC-1);
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Scoreboard shifts every cycle, stalls included; entry 0 takes a bubble unless ID issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_vld  <= '0;
            sb_we   <= '0;
            sb_load <= '0;
            sb_rd   <= '0;
        end else begin
            for (int k = DEPTH-1; k > 0; k--) begin
                sb_vld[k]  <= sb_vld[k-1];
                sb_we[k]   <= sb_we[k-1];
                sb_load[k] <= sb_load[k-1];
                sb_rd[k]   <= sb_rd[k-1];
            end
            sb_vld[0]  <= issue;
            sb_we[0]   <= issue & id_rd_we;
            sb_load[0] <= issue & id_is_load;
            sb_rd[0]   <= issue ? id_rd : '0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) stall_cnt <= stall_cnt + 32'd1;
            if (redir) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
